// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned HDR_BYTES = 2;
  localparam int unsigned LEN_W     = 8 * HDR_BYTES;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDatHi,
    StDatLo,
    StCsum,
    StDone,
    StFail
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream receive handshake plus instruction-memory write port.
interface program_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) ();

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory,
// then raises ready for the processor.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  program_loader_if.master  bus,
  output logic              ready,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  state_e           state;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] len;
  logic [7:0]       dat_hi;
  logic [7:0]       csum;

  logic       fire;
  logic [7:0] csum_nxt;
  logic [LEN_W-1:0] len_nxt;

  always_comb begin
    fire     = bus.rx_valid && bus.rx_ready;
    csum_nxt = csum ^ bus.rx_data;
    len_nxt  = {len_hi, bus.rx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= StIdle;
      len_hi         <= '0;
      len            <= '0;
      dat_hi         <= '0;
      csum           <= '0;
      bus.rx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      ready          <= 1'b0;
      busy           <= 1'b0;
      err            <= 1'b0;
      word_cnt       <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      unique case (state)
        StIdle, StDone, StFail: begin
          if (start) begin
            state        <= StLenHi;
            err          <= 1'b0;
            word_cnt     <= '0;
            csum         <= '0;
            ready        <= 1'b0;
            bus.rx_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end
        StLenHi: begin
          if (fire) begin
            len_hi <= bus.rx_data;
            csum   <= csum_nxt;
            state  <= StLenLo;
          end
        end
        StLenLo: begin
          if (fire) begin
            len  <= len_nxt;
            csum <= csum_nxt;
            if (32'(len_nxt) > Depth) begin
              state        <= StFail;
              err          <= 1'b1;
              bus.rx_ready <= 1'b0;
              busy         <= 1'b0;
            end else if (len_nxt == '0) begin
              state <= StCsum;
            end else begin
              state <= StDatHi;
            end
          end
        end
        StDatHi: begin
          if (fire) begin
            dat_hi <= bus.rx_data;
            csum   <= csum_nxt;
            state  <= StDatLo;
          end
        end
        StDatLo: begin
          if (fire) begin
            csum           <= csum_nxt;
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= word_cnt[ADDR_W-1:0];
            bus.imem_wdata <= {dat_hi, bus.rx_data};
            if (32'(word_cnt) < Depth) word_cnt <= word_cnt + 1'b1;
            state <= (32'(word_cnt) + 32'd1 == 32'(len)) ? StCsum : StDatHi;
          end
        end
        StCsum: begin
          if (fire) begin
            bus.rx_ready <= 1'b0;
            busy         <= 1'b0;
            if (bus.rx_data == csum) begin
              state <= StDone;
              ready <= 1'b1;
            end else begin
              state <= StFail;
              err   <= 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard.
module tb_program_loader;
  import loader_pkg::*;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              ready;
  logic              busy;
  logic              err;
  logic [ADDR_W:0]   word_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  nominal[$] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h42};

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .ready    (ready),
    .busy     (busy),
    .err      (err),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("write", {8'h00, bus.imem_addr, bus.imem_wdata}, exp_q.pop_front());
    end
  end

  task automatic push_nominal();
    exp_q.push_back({8'h00, 8'd0, 16'h1234});
    exp_q.push_back({8'h00, 8'd1, 16'hABCD});
    exp_q.push_back({8'h00, 8'd2, 16'h0001});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.rx_ready !== 1'b1) chk("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gap_max, input int start_at);
    for (int i = 0; i < s.size(); i++) begin
      int gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (i == start_at) pulse_start();
      repeat (gap) @(negedge clk);
      send(s[i]);
    end
  endtask

  task automatic chk_status(input string tag, input logic r, input logic e,
                            input logic [ADDR_W:0] wc);
    chk({tag, "_ready"}, 32'(ready), 32'(r));
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'(wc));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    chk({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
    chk({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
  endtask

  initial begin
    logic [7:0] s[$];
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal load
    push_nominal();
    pulse_start();
    chk("nom_busy", 32'(busy), 32'd1);
    send_stream(nominal, 0, -1);
    chk_status("nominal", 1'b1, 1'b0, 9'd3);

    // Bad checksum
    push_nominal();
    s = nominal;
    s[8] = 8'h43;
    pulse_start();
    send_stream(s, 0, -1);
    chk_status("bad_csum", 1'b0, 1'b1, 9'd3);

    // Empty program
    pulse_start();
    s = '{8'h00, 8'h00, 8'h00};
    send_stream(s, 0, -1);
    chk_status("empty", 1'b1, 1'b0, 9'd0);

    // Oversize: N = 257
    pulse_start();
    s = '{8'h01, 8'h01};
    send_stream(s, 0, -1);
    chk_status("oversize", 1'b0, 1'b1, 9'd0);
    bus.rx_data  = 8'h55;
    bus.rx_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("oversize_ignore_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("oversize_ignore_err", 32'(err), 32'd1);
    bus.rx_valid = 1'b0;

    // Backpressure with a start pulse mid-stream
    push_nominal();
    pulse_start();
    send_stream(nominal, 5, 4);
    chk_status("backpressure", 1'b1, 1'b0, 9'd3);

    // Async reset after the second word
    push_nominal();
    pulse_start();
    s = nominal[0:5];
    send_stream(s, 0, -1);
    @(negedge clk);
    chk("mid_reset_pending", 32'(exp_q.size()), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reload after reset
    push_nominal();
    pulse_start();
    send_stream(nominal, 0, -1);
    chk_status("reload", 1'b1, 1'b0, 9'd3);

    // Start from DONE drops ready at that edge
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_ready", 32'(ready), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
